// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// Ports: op/funct3/funct7b5/zero flow datapath->controller; PC/IR/memory/ALU/regfile
//        steering and dbg_state flow controller->datapath. master = controller side.
interface multicycle_control_fsm_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               zero;
  logic               pc_write;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_control;
  logic [1:0]         imm_src;
  logic               reg_write;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_write, dbg_state
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_write, dbg_state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main Moore controller of the multicycle RV32I core: sequences fetch/decode/
// execute/memory/writeback, decodes ALU operation and immediate type.
// Ports: clk, reset (sync, active-high), bus (master modport: instruction fields
//        and zero flag in; PC/IR/mem/ALU/regfile steering and dbg_state out).
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 'd0,
    S_DECODE   = 'd1,
    S_MEMADR   = 'd2,
    S_MEMREAD  = 'd3,
    S_MEMWB    = 'd4,
    S_MEMWRITE = 'd5,
    S_EXECR    = 'd6,
    S_ALUWB    = 'd7,
    S_EXECI    = 'd8,
    S_JAL      = 'd9,
    S_BEQ      = 'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  state_t     r_state;
  state_t     w_next;
  logic       w_pc_update;
  logic       w_branch;
  logic [1:0] w_aluop;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_pc_write;
  logic [2:0] w_alu_control;
  logic [1:0] w_imm_src;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next state plus per-state control decode.
  always_comb begin
    w_next       = S_FETCH;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_aluop      = 2'b00;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        w_next       = S_DECODE;
        w_ir_write   = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_pc_update  = 1'b1;
      end
      S_DECODE: begin
        // Branch target is computed here speculatively into ALUOut.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECR;
          OP_ITYPE:     w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BR:        w_next = S_BEQ;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_next    = S_MEMWB;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        // Address held on ALUOut through writeback so the load address never glitches.
        w_next       = S_FETCH;
        w_adr_src    = 1'b1;
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_next      = S_FETCH;
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        w_next      = S_ALUWB;
        w_alu_src_a = 2'b10;
        w_aluop     = 2'b10;
      end
      S_EXECI: begin
        w_next      = S_ALUWB;
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_aluop     = 2'b10;
      end
      S_ALUWB: begin
        w_next      = S_FETCH;
        w_reg_write = 1'b1;
      end
      S_JAL: begin
        w_next      = S_ALUWB;
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        w_next      = S_FETCH;
        w_alu_src_a = 2'b10;
        w_aluop     = 2'b01;
        w_branch    = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    // Reset forces FETCH steering with every write strobe suppressed.
    if (reset) begin
      w_pc_update  = 1'b0;
      w_branch     = 1'b0;
      w_aluop      = 2'b00;
      w_adr_src    = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_result_src = 2'b10;
      w_alu_src_a  = 2'b00;
      w_alu_src_b  = 2'b10;
    end
  end

  // funct3[0] flips the branch sense: beq takes on zero, bne on non-zero.
  assign w_pc_write = w_pc_update | (w_branch & (bus.zero ^ bus.funct3[0]));

  always_comb begin
    w_alu_control = 3'b000;
    case (w_aluop)
      2'b00: w_alu_control = 3'b000;
      2'b01: w_alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  w_alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_control = 3'b101;
          3'b110:  w_alu_control = 3'b011;
          3'b111:  w_alu_control = 3'b010;
          default: w_alu_control = 3'b000;
        endcase
      end
      default: w_alu_control = 3'b000;
    endcase
  end

  always_comb begin
    w_imm_src = 2'b00;
    case (bus.op)
      OP_SW:   w_imm_src = 2'b01;
      OP_BR:   w_imm_src = 2'b10;
      OP_JAL:  w_imm_src = 2'b11;
      default: w_imm_src = 2'b00;
    endcase
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.adr_src     = w_adr_src;
  assign bus.mem_write   = w_mem_write;
  assign bus.ir_write    = w_ir_write;
  assign bus.result_src  = w_result_src;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_control = w_alu_control;
  assign bus.imm_src     = w_imm_src;
  assign bus.reg_write   = w_reg_write;
  assign bus.dbg_state   = r_state;

endmodule
